// File: rtl/wb_trace_recorder.sv
// wb_trace_recorder: taps the CPU write-back ports, builds one trace record per
// capture cycle and streams the records out of a show-ahead FIFO over a
// valid/ready handshake. A refused push halts capture until clear.
module wb_trace_recorder #(
    parameter int DEPTH       = 16,
    parameter int SKIP_CYCLES = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_en,
    input  logic             clear,
    input  logic             reg_write_enable,
    input  logic [4:0]       reg_write_addr,
    input  logic [31:0]      reg_write_data,
    input  logic             hilo_we,
    input  logic [31:0]      hi_data,
    input  logic [31:0]      lo_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [CNT_W-1:0] out_index,
    output logic [4:0]       out_addr,
    output logic [31:0]      out_data0,
    output logic [31:0]      out_data1,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WARM_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);

    localparam logic [1:0] KIND_SKIP = 2'b00;
    localparam logic [1:0] KIND_REG  = 2'b01;
    localparam logic [1:0] KIND_HILO = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2,
        HALTED  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] index;
        logic [4:0]       addr;
        logic [31:0]      data0;
        logic [31:0]      data1;
    } rec_t;

    state_t            state, state_next;
    logic [WARM_W-1:0] warm_cnt;
    logic [CNT_W-1:0]  idx_cnt;
    logic [AW:0]       wr_ptr, rd_ptr;
    rec_t              mem [DEPTH];
    rec_t              new_rec;
    rec_t              head_rec;
    logic              empty, full;
    logic              pop, capture, push_ok, push_drop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready && !clear;
    assign capture   = (state == CAPTURE) && capture_en && !clear;
    assign push_ok   = capture && (!full || pop);
    assign push_drop = capture && full && !pop;

    // State register; clear returns to IDLE through the next-state logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: arm, warm up, capture, halt on a lost record
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture_en) state_next = (SKIP_CYCLES == 0) ? CAPTURE : WARMUP;
            end
            WARMUP: begin
                if (!capture_en)                 state_next = IDLE;
                else if (warm_cnt == WARM_LAST)  state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!capture_en)     state_next = IDLE;
                else if (push_drop)  state_next = HALTED;
            end
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    // Warm-up counter only advances on enabled WARMUP cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              warm_cnt <= '0;
        else if (clear || state != WARMUP)     warm_cnt <= '0;
        else if (capture_en)                   warm_cnt <= warm_cnt + 1'b1;
    end

    // Record index advances every capture cycle, even when the push is lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          idx_cnt <= CNT_W'(1);
        else if (clear)    idx_cnt <= CNT_W'(1);
        else if (capture)  idx_cnt <= idx_cnt + 1'b1;
    end

    // Build the record for this cycle; reg write wins over hilo, unused fields zero
    always_comb begin
        new_rec       = '0;
        new_rec.index = idx_cnt;
        new_rec.kind  = KIND_SKIP;
        if (reg_write_enable) begin
            new_rec.kind  = KIND_REG;
            new_rec.addr  = reg_write_addr;
            new_rec.data0 = reg_write_data;
        end else if (hilo_we) begin
            new_rec.kind  = KIND_HILO;
            new_rec.data0 = hi_data;
            new_rec.data1 = lo_data;
        end
    end

    // Storage array needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    // FIFO pointers with one extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (push_drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end

    // Present the FIFO head, forced to zero whenever nothing is valid
    always_comb begin
        head_rec = '0;
        if (!empty) head_rec = mem[rd_ptr[AW-1:0]];
    end

    assign out_valid = !empty;
    assign out_kind  = head_rec.kind;
    assign out_index = head_rec.index;
    assign out_addr  = head_rec.addr;
    assign out_data0 = head_rec.data0;
    assign out_data1 = head_rec.data1;

endmodule

// File: tb/tb_wb_trace_recorder.sv
// tb_wb_trace_recorder: directed self-checking bench for wb_trace_recorder
// (DEPTH=16, SKIP_CYCLES=5, CNT_W=16).
module tb_wb_trace_recorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_en;
    logic        clear;
    logic        reg_write_enable;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        hilo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [15:0] out_index;
    logic [4:0]  out_addr;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    wb_trace_recorder #(.DEPTH(16), .SKIP_CYCLES(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .clear(clear),
        .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .hilo_we(hilo_we),
        .hi_data(hi_data), .lo_data(lo_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_index(out_index), .out_addr(out_addr), .out_data0(out_data0),
        .out_data1(out_data1), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRecord(input string tag, input logic [1:0] kind, input logic [15:0] index,
                               input logic [4:0] addr, input logic [31:0] d0, input logic [31:0] d1);
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".kind"},  64'(out_kind),  64'(kind));
        checkOutput({tag, ".index"}, 64'(out_index), 64'(index));
        checkOutput({tag, ".addr"},  64'(out_addr),  64'(addr));
        checkOutput({tag, ".data0"}, 64'(out_data0), 64'(d0));
        checkOutput({tag, ".data1"}, 64'(out_data1), 64'(d1));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".valid"},    64'(out_valid),  64'd0);
        checkOutput({tag, ".kind"},     64'(out_kind),   64'd0);
        checkOutput({tag, ".index"},    64'(out_index),  64'd0);
        checkOutput({tag, ".addr"},     64'(out_addr),   64'd0);
        checkOutput({tag, ".data0"},    64'(out_data0),  64'd0);
        checkOutput({tag, ".data1"},    64'(out_data1),  64'd0);
        checkOutput({tag, ".overflow"}, 64'(overflow),   64'd0);
        checkOutput({tag, ".drops"},    64'(drop_count), 64'd0);
    endtask

    task automatic clearPulse();
        clear = 1'b1;
        applyStimulus(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; capture_en = 1'b0; clear = 1'b0; out_ready = 1'b1;
        reg_write_enable = 1'b0; reg_write_addr = '0; reg_write_data = '0;
        hilo_we = 1'b0; hi_data = '0; lo_data = '0;
        applyStimulus(2);
        checkIdle("reset");
        rst = 1'b1;

        // Skip records after warm-up, one per cycle
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput("warmup.valid", 64'(out_valid), 64'd0);
        end
        applyStimulus(1);
        checkRecord("skip1", 2'b00, 16'd1, 5'd0, 32'd0, 32'd0);
        applyStimulus(1);
        checkRecord("skip2", 2'b00, 16'd2, 5'd0, 32'd0, 32'd0);
        applyStimulus(1);
        checkRecord("skip3", 2'b00, 16'd3, 5'd0, 32'd0, 32'd0);

        // Clear, then reg/hilo records and priority
        clearPulse();
        checkIdle("clear1");
        applyStimulus(6);
        checkOutput("warmup2.valid", 64'(out_valid), 64'd0);
        reg_write_enable = 1'b1; reg_write_addr = 5'd3; reg_write_data = 32'h0000_1234;
        applyStimulus(1);
        checkRecord("reg", 2'b01, 16'd1, 5'd3, 32'h0000_1234, 32'd0);
        reg_write_addr = 5'd7; reg_write_data = 32'hDEAD_BEEF;
        hilo_we = 1'b1; hi_data = 32'hAAAA_0000; lo_data = 32'h0000_5555;
        applyStimulus(1);
        checkRecord("prio", 2'b01, 16'd2, 5'd7, 32'hDEAD_BEEF, 32'd0);
        reg_write_enable = 1'b0;
        applyStimulus(1);
        checkRecord("hilo", 2'b10, 16'd3, 5'd0, 32'hAAAA_0000, 32'h0000_5555);
        hilo_we = 1'b0;

        // Fill with out_ready low, overflow on the 17th capture
        capture_en = 1'b0;
        clearPulse();
        checkIdle("clear2");
        capture_en = 1'b1; out_ready = 1'b0;
        applyStimulus(6 + 16);
        checkRecord("full.head", 2'b00, 16'd1, 5'd0, 32'd0, 32'd0);
        checkOutput("full.overflow", 64'(overflow), 64'd0);
        applyStimulus(1);
        checkOutput("ovf.overflow", 64'(overflow), 64'd1);
        checkOutput("ovf.drops", 64'(drop_count), 64'd1);
        checkRecord("ovf.stable", 2'b00, 16'd1, 5'd0, 32'd0, 32'd0);
        applyStimulus(3);
        checkOutput("halted.drops", 64'(drop_count), 64'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            checkOutput("drain.valid", 64'(out_valid), 64'd1);
            checkOutput("drain.index", 64'(out_index), 64'(k));
            applyStimulus(1);
        end
        checkOutput("drained.valid", 64'(out_valid), 64'd0);
        checkOutput("drained.overflow", 64'(overflow), 64'd1);

        // Full FIFO with a pop alongside the push: no loss, occupancy stays 16
        capture_en = 1'b0;
        clearPulse();
        capture_en = 1'b1; out_ready = 1'b0;
        applyStimulus(6 + 16);
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("fullpop.overflow", 64'(overflow), 64'd0);
        checkOutput("fullpop.index", 64'(out_index), 64'd2);
        out_ready = 1'b0;
        applyStimulus(1);
        checkOutput("stillfull.overflow", 64'(overflow), 64'd1);
        checkOutput("stillfull.drops", 64'(drop_count), 64'd1);

        // Reset in the middle of a drain
        out_ready = 1'b1;
        applyStimulus(2);
        checkOutput("middrain.index", 64'(out_index), 64'd4);
        #2 rst = 1'b0;
        #1;
        checkIdle("asyncreset");
        rst = 1'b1;
        applyStimulus(1);
        checkIdle("postreset");

        // Clear during capture, then restart at index 1 after warm-up
        applyStimulus(6);
        checkRecord("recap", 2'b00, 16'd1, 5'd0, 32'd0, 32'd0);
        clearPulse();
        checkIdle("clear3");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput("warmup3.valid", 64'(out_valid), 64'd0);
        end
        applyStimulus(1);
        checkRecord("restart", 2'b00, 16'd1, 5'd0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_recorder.md
# wb_trace_recorder

Captures the CPU's per-cycle write-back activity (GPR write, HI/LO write, or nothing) into a small FIFO and streams the resulting trace records out over a valid/ready handshake. It is the producer side of the golden-trace check performed by the CPU bench. It sits beside `cpu` and taps `reg_write_enable/addr/data` and `hilo_we/hi_i/lo_i`, so an on-chip or off-chip consumer can compare against `.ans` traces without hierarchical probing.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `SKIP_CYCLES`, 5: capture cycles discarded after arming (pipeline fill).
- `CNT_W`, 16: width of the record index.
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `capture_en` in 1: level; high arms and keeps capture running.
- `clear` in 1: synchronous; empties FIFO, clears index, overflow and drop count, returns to IDLE.
- `reg_write_enable` in 1, `reg_write_addr` in 5, `reg_write_data` in 32: GPR write-back tap.
- `hilo_we` in 1, `hi_data` in 32, `lo_data` in 32: HI/LO write tap.
- `out_valid` out 1, `out_ready` in 1: record handshake.
- `out_kind` out 2: 00 skip, 01 reg, 10 hilo, 11 reserved.
- `out_index` out CNT_W: cycle number of the record, first record = 1.
- `out_addr` out 5: register address for reg records, else 0.
- `out_data0` out 32: reg data or HI; 0 for skip.
- `out_data1` out 32: LO for hilo records, else 0.
- `overflow` out 1: sticky; a record was lost.
- `drop_count` out 8: saturating count of lost records.

## Operation
- States:
  - IDLE: no capture. Goes to WARMUP when `capture_en`=1.
  - WARMUP: counts `SKIP_CYCLES` cycles with `capture_en`=1, then goes to CAPTURE. With `SKIP_CYCLES`=0 it goes straight to CAPTURE.
  - CAPTURE: one record per cycle.
  - HALTED: entered on the first lost record; no capture until `clear`.
- `capture_en`=0 in WARMUP or CAPTURE returns the FSM to IDLE. The index is not reset, and FIFO contents remain drainable.
- Record kind priority, matching the bench: `reg_write_enable` beats `hilo_we`, which beats skip. Unused fields are forced to 0.
- Index increments once per CAPTURE cycle, starting at 1 after reset or `clear`, and wraps modulo 2^CNT_W.
- Push: every CAPTURE cycle. It is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Push refused:
  - `overflow` is set, `drop_count` is incremented (saturating at 255), and the FSM goes to HALTED.
  - The index still advances, so the consumer sees the gap.
- Pop: `out_valid` && `out_ready`. Show-ahead FIFO; the head is presented on the `out_*` fields.
- `clear` has priority over all other inputs in the same cycle, and that cycle's event is discarded.

## Timing
- After reset: FSM IDLE; FIFO empty; `out_valid`=0; `out_kind`=0; `out_index`=0; `out_addr`=0; `out_data0`=0; `out_data1`=0; `overflow`=0; `drop_count`=0; index counter=1.
- Taps are sampled on the rising edge.
- Latency: a record pushed at edge N is visible with `out_valid`=1 after edge N when the FIFO was empty (1 cycle).
- `out_*` must stay stable while `out_valid`=1 and `out_ready`=0.
- First CAPTURE cycle is the (`SKIP_CYCLES`+1)-th cycle with `capture_en` high after leaving IDLE.
- Full and empty use pointers one bit wider than log2(`DEPTH`). Simultaneous push and pop keeps occupancy unchanged, including when full or empty. A pop on empty is ignored.
- Reset asserted mid-stream clears everything asynchronously, including any partly drained record. No output glitches to a stale record after reset deassert.

## Test plan
- Reset then `capture_en`=1, taps idle, `out_ready`=1 -> no record for 5 cycles, then kind 00 with index 1, 2, 3… one per cycle.
- Reg write $3=0x00001234 on the first capture cycle -> record kind 01, index 1, addr 3, data0 0x00001234, data1 0.
- `reg_write_enable` and `hilo_we` both high (hi=0xAAAA0000, lo=0x5555) -> kind 01 only. Next cycle hilo alone -> kind 10, data0 0xAAAA0000, data1 0x00005555, addr 0.
- `out_ready`=0 with continuous capture, `DEPTH`=16:
  - 16 records are held.
  - 17th cycle: `overflow`=1, `drop_count`=1, FSM HALTED.
  - Drain gives indices 1..16 in order, then `out_valid`=0.
- FIFO full with `out_ready`=1 in the same cycle as a push -> no overflow; occupancy stays 16.
- Assert `rst`=0 mid-drain, release, then `clear` pulse during capture -> all outputs at reset values. A new capture restarts at index 1 after 5 skip cycles.
